// File: rtl/seq_shift_pkg.sv
// Shared types for the sequential shifter: shift modes and FSM states.
package seq_shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_step.sv
// One combinational shift step of 0..STEP bits; with SEQ_SHIFT_STICKY_EN it also
// reports the OR of the bits dropped off the LSB by right shifts.
module seq_shift_step
    import seq_shift_pkg::*;
#(
    parameter int N    = 8,
    parameter int STEP = 1,
    parameter int KW   = $clog2(STEP + 1)
) (
    input  logic [N-1:0]  data,
    input  shift_mode_t   mode,
    input  logic [KW-1:0] k,
    output logic [N-1:0]  shifted
`ifdef SEQ_SHIFT_STICKY_EN
    ,
    output logic          lost
`endif
);

    always_comb begin
        shifted = data;
        unique case (mode)
            SH_LSL: shifted = data << k;
            SH_LSR: shifted = data >> k;
            // The MSB is never altered by ASR, so stepping keeps the original sign.
            SH_ASR: shifted = $signed(data) >>> k;
            SH_ROR: shifted = (data >> k) | (data << (N - 32'(k)));
            default: shifted = data;
        endcase
    end

`ifdef SEQ_SHIFT_STICKY_EN
    logic [N-1:0] low_mask;

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign low_mask[gi] = (gi < 32'(k));
    end

    assign lost = ((mode == SH_LSR) || (mode == SH_ASR)) && (|(data & low_mask));
`endif

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter, up to STEP bits per clock, valid/ready on both sides.
// Optional SEQ_SHIFT_STICKY_EN adds down_sticky (OR of bits lost by LSR/ASR).
module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter int N    = 8,
    parameter int STEP = 1,
    parameter int AW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [AW-1:0] up_amt,
    input  logic [1:0]    up_mode,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
`ifdef SEQ_SHIFT_STICKY_EN
    ,
    output logic          down_sticky
`endif
);

    localparam int KW = $clog2(STEP + 1);

    state_t        state_reg;
    shift_mode_t   mode_reg;
    logic [N-1:0]  data_reg;
    logic [N-1:0]  down_data_reg;
    logic [AW-1:0] rem_reg;
    logic          down_valid_reg;

    logic [KW-1:0] k;
    logic [AW-1:0] rem_next;
    logic [N-1:0]  step_data;
    logic          accept;

    assign up_ready   = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && down_ready);
    assign accept     = up_valid && up_ready;
    assign down_valid = down_valid_reg;
    assign down_data  = down_data_reg;

    always_comb begin
        k = (32'(rem_reg) >= STEP) ? KW'(STEP) : KW'(rem_reg);
    end

    // k never exceeds rem_reg, so narrowing it to AW bits is lossless.
    assign rem_next = rem_reg - AW'(k);

`ifdef SEQ_SHIFT_STICKY_EN
    logic step_lost;
    logic sticky_reg;

    assign down_sticky = sticky_reg;
`endif

    seq_shift_step #(
        .N    (N),
        .STEP (STEP)
    ) u_step (
        .data    (data_reg),
        .mode    (mode_reg),
        .k       (k),
        .shifted (step_data)
`ifdef SEQ_SHIFT_STICKY_EN
        ,
        .lost    (step_lost)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            mode_reg       <= SH_LSL;
            data_reg       <= '0;
            rem_reg        <= '0;
            down_valid_reg <= 1'b0;
            down_data_reg  <= '0;
`ifdef SEQ_SHIFT_STICKY_EN
            sticky_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        data_reg <= up_data;
                        mode_reg <= shift_mode_t'(up_mode);
                        rem_reg  <= up_amt;
`ifdef SEQ_SHIFT_STICKY_EN
                        sticky_reg <= 1'b0;
`endif
                        if (up_amt == '0) begin
                            state_reg      <= ST_DONE;
                            down_valid_reg <= 1'b1;
                            down_data_reg  <= up_data;
                        end else begin
                            state_reg      <= ST_SHIFT;
                            down_valid_reg <= 1'b0;
                            down_data_reg  <= '0;
                        end
                    end else if ((state_reg == ST_DONE) && down_ready) begin
                        state_reg      <= ST_IDLE;
                        down_valid_reg <= 1'b0;
                        down_data_reg  <= '0;
                    end
                end
                ST_SHIFT: begin
                    data_reg <= step_data;
                    rem_reg  <= rem_next;
`ifdef SEQ_SHIFT_STICKY_EN
                    sticky_reg <= sticky_reg | step_lost;
`endif
                    if (rem_next == '0) begin
                        state_reg      <= ST_DONE;
                        down_valid_reg <= 1'b1;
                        down_data_reg  <= step_data;
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    down_valid_reg <= 1'b0;
                    down_data_reg  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parametrised, multi-cycle shifter for N-bit operands: logical left, logical right, arithmetic right and rotate right, by a runtime amount.
- Shifts by up to STEP bits per clock under a small FSM.
- Uses a valid/ready handshake on both sides.
- Sits between an operand source and a result sink wherever a full barrel shifter is too costly.

Parameters:
- N, 8, operand width in bits; N >= 2.
- STEP, 1, maximum bits shifted per cycle; 1 <= STEP <= N.
- AW, $clog2(N), shift-amount width (derived; do not override).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- up_valid  input  1  operand valid.
- up_ready  output  1  unit can accept an operand.
- up_data  input  N  operand.
- up_amt  input  AW  shift amount, 0..N-1.
- up_mode  input  2  shift_mode_t: 0 LSL, 1 LSR, 2 ASR, 3 ROR.
- down_valid  output  1  result valid.
- down_ready  input  1  sink accepts result.
- down_data  output  N  shifted result.

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is asynchronous and active-low. Asserting rst_n = 0 immediately forces state IDLE, down_valid = 0, down_data = 0, internal remaining count and mode to 0. This applies mid-operation; any in-flight operand is discarded.
- States: IDLE, SHIFT, DONE.
- up_ready = (state == IDLE) || (state == DONE && down_ready). It is combinational from down_ready.
- Accept occurs when up_valid && up_ready at a rising edge:
  - Capture data, mode and rem = up_amt.
  - If up_amt == 0, go to DONE; else go to SHIFT.
- SHIFT, each cycle:
  - k = min(STEP, rem).
  - data <= shift_step(data, mode, k); rem <= rem - k.
  - When rem - k == 0, go to DONE.
- DONE: down_valid = 1 and down_data holds the result.
  - On down_valid && down_ready: if a new accept also occurs that cycle, load it (back-to-back, no bubble); else go to IDLE.
  - down_valid and down_data stay stable while down_ready = 0.
- Latency: ceil(amt/STEP) edges from accept to down_valid, minimum 1 (amt = 0).
- Mode arithmetic, all N-bit and unsigned except ASR:
  - LSL fills zeros from the LSB.
  - LSR fills zeros from the MSB.
  - ASR replicates the original MSB.
  - ROR wraps bits from the LSB into the MSB.
- up_data, up_amt and up_mode are ignored when no accept occurs.
- down_data is 0 in IDLE.

Optional Feature:
- Macro: SEQ_SHIFT_STICKY_EN.
- Defined: adds output down_sticky (1 bit), the OR of all bits shifted out of the LSB during LSR/ASR.
  - It is 0 for LSL, ROR and amt = 0.
  - It is valid and stable with down_valid; reset value 0; cleared on each accept.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package seq_shift_pkg contains:
  - typedef enum logic [1:0] shift_mode_t {SH_LSL, SH_LSR, SH_ASR, SH_ROR}.
  - FSM state enum {ST_IDLE, ST_SHIFT, ST_DONE}.
- One combinational sub-module, seq_shift_step:
  - Parameters N, STEP.
  - Inputs data, mode, k (0..STEP).
  - Outputs shifted data and, under the macro, lost-bit OR.
  - Instantiated once in the datapath.

Test Plan:
- N=8, STEP=2, LSL, a=8'h96, amt=3 -> down_data=8'hB0; down_valid 2 edges after accept; sticky=0.
- N=8, STEP=2, LSR, a=8'h96, amt=3 -> 8'h12; sticky=1 (bits 110 lost).
- N=8, STEP=1, ASR, a=8'h96, amt=3 -> 8'hF2 after 3 edges; ROR same operand -> 8'hD2.
- amt=0, any mode, a=8'h5A -> 8'h5A, down_valid 1 edge after accept. Hold down_ready=0 for 5 cycles -> output stable and up_ready=0. Then down_ready=1 with up_valid=1 -> new operand accepted the same edge, no idle cycle.
- Deassert rst_n mid-SHIFT (LSR, a=8'hFF, amt=7, after 2 edges) -> down_valid=0 and up_ready=1 immediately after release. A following LSL 8'h01 by 1 -> 8'h02.
- Random N=16, STEP=3, all modes/amounts vs reference model, with random down_ready stalls -> exact match, no drop or duplicate.
